// File: rtl/activation_memory_pkg.sv
// Shared types and helpers for the activation memory sequencer.
package activation_memory_pkg;

    typedef enum logic {IDLE, DRAIN} state_e;

    localparam int MAX_BANKS = 32;

    function automatic logic [MAX_BANKS-1:0] onehot(input int unsigned bank);
        return {{(MAX_BANKS-1){1'b0}}, 1'b1} << bank;
    endfunction

endpackage

// File: rtl/skew_addr_gen.sv
// Diagonal read-address generator: bank b reads row t-b while that row is inside [0, R).
module skew_addr_gen #(
    parameter int ADDR_WIDTH = 5,
    parameter int BRAM_COUNT = 5
) (
    input  logic [ADDR_WIDTH:0]              i_step,
    input  logic [ADDR_WIDTH:0]              i_rows,
    output logic [BRAM_COUNT*ADDR_WIDTH-1:0] o_addr,
    output logic [BRAM_COUNT-1:0]            o_vld
);
    localparam int STEP_W = ADDR_WIDTH + 1;

    logic [STEP_W-1:0] w_off;

    always_comb begin
        o_addr = '0;
        o_vld  = '0;
        w_off  = '0;
        for (int b = 0; b < BRAM_COUNT; b++) begin
            w_off = i_step - STEP_W'(b);
            if ((i_step >= STEP_W'(b)) && (w_off < i_rows)) begin
                o_vld[b]                               = 1'b1;
                o_addr[b*ADDR_WIDTH +: ADDR_WIDTH]     = w_off[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/activation_memory_ctrl.sv
// Stripes a byte stream round-robin across BRAM banks and drains stored rows
// with a per-bank diagonal skew for the systolic array.
module activation_memory_ctrl
    import activation_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int BRAM_COUNT = 5,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_start,
    input  logic [ADDR_WIDTH:0]              rd_rows,
    output logic                             busy,
    output logic                             rd_done,
    output logic [BRAM_COUNT-1:0]            lane_valid,
    output logic [ADDR_WIDTH:0]              fill_rows,
    output logic [BRAM_COUNT-1:0]            mem_en_bus,
    output logic [ADDR_WIDTH-1:0]            mem_w_addr,
    output logic [DATA_WIDTH-1:0]            mem_data_in,
    output logic [BRAM_COUNT*ADDR_WIDTH-1:0] mem_r_addr,
    output logic [BRAM_COUNT*SEL_WIDTH-1:0]  mem_data_out_sels
);
    localparam int STEP_W = ADDR_WIDTH + 1;
    localparam int BANK_W = (BRAM_COUNT > 1) ? $clog2(BRAM_COUNT) : 1;
    localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(BRAM_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = {ADDR_WIDTH{1'b1}};

    state_e                          r_state;
    logic [BANK_W-1:0]               r_bank;
    logic [ADDR_WIDTH-1:0]           r_row;
    logic                            r_full;
    logic [STEP_W-1:0]               r_fill_rows;
    logic [STEP_W-1:0]               r_step;
    logic [STEP_W-1:0]               r_rows;
    logic                            r_issuing;
    logic                            r_last_issue;
    logic [BRAM_COUNT-1:0]           r_issue_vld;
    logic                            r_busy;
    logic                            r_rd_done;
    logic [BRAM_COUNT-1:0]           r_lane_valid;
    logic [BRAM_COUNT-1:0]           r_en_bus;
    logic [ADDR_WIDTH-1:0]           r_w_addr;
    logic [DATA_WIDTH-1:0]           r_data_in;
    logic [BRAM_COUNT*ADDR_WIDTH-1:0] r_r_addr;

    logic                            w_accept;
    logic                            w_start;
    logic [STEP_W-1:0]               w_fill_next;
    logic [STEP_W-1:0]               w_eff_rows;
    logic [STEP_W-1:0]               w_step;
    logic [STEP_W-1:0]               w_rows;
    logic [STEP_W-1:0]               w_last_step;
    logic [BRAM_COUNT*ADDR_WIDTH-1:0] w_addr;
    logic [BRAM_COUNT-1:0]           w_vld;

    assign wr_ready   = (r_state == IDLE) && !r_full && rst_n;
    assign w_accept   = wr_valid && wr_ready;

    // A beat landing in bank 0 opens a new row, so it counts toward a same-cycle drain.
    assign w_fill_next = (w_accept && (r_bank == '0)) ? ({1'b0, r_row} + STEP_W'(1)) : r_fill_rows;
    assign w_eff_rows  = (rd_rows < w_fill_next) ? rd_rows : w_fill_next;
    assign w_start     = rd_start && (r_state == IDLE) && (w_eff_rows != '0);

    assign w_step      = (r_state == IDLE) ? '0 : r_step;
    assign w_rows      = (r_state == IDLE) ? w_eff_rows : r_rows;
    assign w_last_step = w_rows + STEP_W'(BRAM_COUNT - 2);

    skew_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BRAM_COUNT (BRAM_COUNT)
    ) u_skew (
        .i_step (w_step),
        .i_rows (w_rows),
        .o_addr (w_addr),
        .o_vld  (w_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bank       <= '0;
            r_row        <= '0;
            r_full       <= 1'b0;
            r_fill_rows  <= '0;
            r_step       <= '0;
            r_rows       <= '0;
            r_issuing    <= 1'b0;
            r_last_issue <= 1'b0;
            r_issue_vld  <= '0;
            r_busy       <= 1'b0;
            r_rd_done    <= 1'b0;
            r_lane_valid <= '0;
            r_en_bus     <= '0;
            r_w_addr     <= '0;
            r_data_in    <= '0;
            r_r_addr     <= '0;
        end else begin
            r_en_bus     <= '0;
            r_lane_valid <= r_issue_vld;
            r_rd_done    <= r_last_issue;
            case (r_state)
                IDLE: begin
                    r_fill_rows <= w_fill_next;
                    if (w_accept) begin
                        r_en_bus  <= BRAM_COUNT'(onehot(32'(r_bank)));
                        r_w_addr  <= r_row;
                        r_data_in <= wr_data;
                        if (r_bank == LAST_BANK) begin
                            r_bank <= '0;
                            r_row  <= r_row + ADDR_WIDTH'(1);
                            if (r_row == LAST_ROW) begin
                                r_full <= 1'b1;
                            end
                        end else begin
                            r_bank <= r_bank + BANK_W'(1);
                        end
                    end
                    if (w_start) begin
                        r_state      <= DRAIN;
                        r_busy       <= 1'b1;
                        r_rows       <= w_eff_rows;
                        r_step       <= STEP_W'(1);
                        r_r_addr     <= w_addr;
                        r_issue_vld  <= w_vld;
                        r_issuing    <= (w_last_step != '0);
                        r_last_issue <= (w_last_step == '0);
                    end
                end
                DRAIN: begin
                    if (r_issuing) begin
                        r_r_addr     <= w_addr;
                        r_issue_vld  <= w_vld;
                        r_issuing    <= (r_step != w_last_step);
                        r_last_issue <= (r_step == w_last_step);
                        r_step       <= r_step + STEP_W'(1);
                    end else begin
                        r_r_addr     <= '0;
                        r_issue_vld  <= '0;
                        r_last_issue <= 1'b0;
                    end
                    // The rd_done cycle is the final data cycle; the buffer is empty afterwards.
                    if (r_rd_done) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_bank      <= '0;
                        r_row       <= '0;
                        r_fill_rows <= '0;
                        r_full      <= 1'b0;
                        r_step      <= '0;
                    end
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < BRAM_COUNT; g++) begin : g_sel
            assign mem_data_out_sels[g*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(g);
        end
    endgenerate

    assign busy        = r_busy;
    assign rd_done     = r_rd_done;
    assign lane_valid  = r_lane_valid;
    assign fill_rows   = r_fill_rows;
    assign mem_en_bus  = r_en_bus;
    assign mem_w_addr  = r_w_addr;
    assign mem_data_in = r_data_in;
    assign mem_r_addr  = r_r_addr;

endmodule

// File: tb/tb_activation_memory_ctrl.sv
// Directed bench for activation_memory_ctrl with a behavioural model of the banked memory.
module tb_activation_memory_ctrl;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int BC = 5;
    localparam int SW = 4;

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     wr_data;
    logic              rd_start;
    logic [AW:0]       rd_rows;
    logic              busy;
    logic              rd_done;
    logic [BC-1:0]     lane_valid;
    logic [AW:0]       fill_rows;
    logic [BC-1:0]     mem_en_bus;
    logic [AW-1:0]     mem_w_addr;
    logic [DW-1:0]     mem_data_in;
    logic [BC*AW-1:0]  mem_r_addr;
    logic [BC*SW-1:0]  mem_data_out_sels;

    int total = 0;
    int bad   = 0;

    activation_memory_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BRAM_COUNT (BC),
        .SEL_WIDTH  (SW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .rd_start          (rd_start),
        .rd_rows           (rd_rows),
        .busy              (busy),
        .rd_done           (rd_done),
        .lane_valid        (lane_valid),
        .fill_rows         (fill_rows),
        .mem_en_bus        (mem_en_bus),
        .mem_w_addr        (mem_w_addr),
        .mem_data_in       (mem_data_in),
        .mem_r_addr        (mem_r_addr),
        .mem_data_out_sels (mem_data_out_sels)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory unit model: registered write, registered read through the lane select.
    logic [DW-1:0] mem  [BC][32];
    logic [DW-1:0] dout [BC];
    always @(posedge clk) begin
        for (int b = 0; b < BC; b++) begin
            if (mem_en_bus[b]) mem[b][mem_w_addr] <= mem_data_in;
        end
        for (int l = 0; l < BC; l++) begin
            int s;
            s = int'(mem_data_out_sels[l*SW +: SW]);
            if (s < BC) dout[l] <= mem[s][mem_r_addr[s*AW +: AW]];
            else        dout[l] <= '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_beats(input int n, input int base, output int nrdy);
        nrdy = 0;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(base + i);
            if (!wr_ready) nrdy++;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    // Pulse rd_start (optionally with a beat) and measure busy length and rd_done cycle.
    task automatic run_drain(input logic [AW:0] rows, input logic beat, input logic [DW-1:0] bdata,
                             output int done_c, output int busy_c);
        wr_valid = beat;
        wr_data  = bdata;
        rd_start = 1'b1;
        rd_rows  = rows;
        tick();
        wr_valid = 1'b0;
        rd_start = 1'b0;
        done_c = -1;
        busy_c = 0;
        for (int c = 1; c <= 80; c++) begin
            if (busy) busy_c++;
            if (rd_done && done_c < 0) done_c = c;
            if (!busy) break;
            tick();
        end
    endtask

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic [BC-1:0] en;
        logic [AW-1:0] wa;
        logic [DW-1:0] din;
        logic [AW:0]   fill;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int nrdy, done_c, busy_c;
        logic [BC-1:0] exp_lv;

        vecs[0]  = '{1'b1, 8'd5,  5'b00001, 5'd0, 8'd5,  6'd1};
        vecs[1]  = '{1'b1, 8'd6,  5'b00010, 5'd0, 8'd6,  6'd1};
        vecs[2]  = '{1'b1, 8'd7,  5'b00100, 5'd0, 8'd7,  6'd1};
        vecs[3]  = '{1'b1, 8'd8,  5'b01000, 5'd0, 8'd8,  6'd1};
        vecs[4]  = '{1'b1, 8'd9,  5'b10000, 5'd0, 8'd9,  6'd1};
        vecs[5]  = '{1'b1, 8'd10, 5'b00001, 5'd1, 8'd10, 6'd2};
        vecs[6]  = '{1'b1, 8'd11, 5'b00010, 5'd1, 8'd11, 6'd2};
        vecs[7]  = '{1'b1, 8'd12, 5'b00100, 5'd1, 8'd12, 6'd2};
        vecs[8]  = '{1'b1, 8'd13, 5'b01000, 5'd1, 8'd13, 6'd2};
        vecs[9]  = '{1'b1, 8'd14, 5'b10000, 5'd1, 8'd14, 6'd2};
        vecs[10] = '{1'b1, 8'd15, 5'b00001, 5'd2, 8'd15, 6'd3};
        vecs[11] = '{1'b1, 8'd16, 5'b00010, 5'd2, 8'd16, 6'd3};
        vecs[12] = '{1'b0, 8'h77, 5'b00000, 5'd2, 8'd16, 6'd3};

        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_start = 1'b0; rd_rows = '0;
        tick(); tick(); tick();
        chk("rst mem_en_bus", 32'(mem_en_bus), 32'd0);
        chk("rst mem_w_addr", 32'(mem_w_addr), 32'd0);
        chk("rst mem_data_in", 32'(mem_data_in), 32'd0);
        chk("rst mem_r_addr", 32'(mem_r_addr), 32'd0);
        chk("rst lane_valid", 32'(lane_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rd_done", 32'(rd_done), 32'd0);
        chk("rst fill_rows", 32'(fill_rows), 32'd0);
        chk("rst wr_ready", 32'(wr_ready), 32'd0);
        chk("rst sels", 32'(mem_data_out_sels), 32'h43210);
        rst_n = 1'b1;
        #1;
        chk("post-rst wr_ready", 32'(wr_ready), 32'd1);
        chk("post-rst sels", 32'(mem_data_out_sels), 32'h43210);

        // Striping table
        for (int i = 0; i < 13; i++) begin
            wr_valid = vecs[i].v;
            wr_data  = vecs[i].d;
            tick();
            chk($sformatf("stripe%0d en", i), 32'(mem_en_bus), 32'(vecs[i].en));
            chk($sformatf("stripe%0d waddr", i), 32'(mem_w_addr), 32'(vecs[i].wa));
            chk($sformatf("stripe%0d din", i), 32'(mem_data_in), 32'(vecs[i].din));
            chk($sformatf("stripe%0d fill", i), 32'(fill_rows), 32'(vecs[i].fill));
        end
        wr_valid = 1'b0;

        // Drain 3 rows; a second rd_start at cycle 3 must be ignored
        rd_start = 1'b1; rd_rows = 6'd3;
        tick();
        rd_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp_lv = '0;
            for (int b = 0; b < BC; b++) begin
                if ((c - 2 - b) >= 0 && (c - 2 - b) < 3) exp_lv[b] = 1'b1;
            end
            chk($sformatf("drain c%0d lane_valid", c), 32'(lane_valid), 32'(exp_lv));
            chk($sformatf("drain c%0d rd_done", c), 32'(rd_done), 32'(c == 8));
            chk($sformatf("drain c%0d busy", c), 32'(busy), 32'(c <= 8));
            chk($sformatf("drain c%0d wr_ready", c), 32'(wr_ready), 32'(c >= 9));
            chk($sformatf("drain c%0d fill", c), 32'(fill_rows), (c >= 9) ? 32'd0 : 32'd3);
            for (int b = 0; b < BC; b++) begin
                int r;
                r = c - 2 - b;
                if (r >= 0 && r < 3 && (r * BC + b) < 12)
                    chk($sformatf("drain c%0d lane%0d data", c, b), 32'(dout[b]), 32'(5 + r * BC + b));
            end
            rd_start = (c == 3);
            rd_rows  = 6'd3;
            tick();
        end
        rd_start = 1'b0;

        // Start with empty buffer is ignored
        run_drain(6'd3, 1'b0, 8'h00, done_c, busy_c);
        chk("empty start busy", 32'(busy_c), 32'd0);
        chk("empty start done", done_c, -1);

        // Clamp rd_rows=5 to fill_rows=3
        write_beats(13, 100, nrdy);
        chk("clamp ready", nrdy, 0);
        chk("clamp fill", 32'(fill_rows), 32'd3);
        run_drain(6'd5, 1'b0, 8'h00, done_c, busy_c);
        chk("clamp done cycle", done_c, 8);
        chk("clamp busy cycles", busy_c, 8);
        chk("clamp wr_ready after", 32'(wr_ready), 32'd1);
        chk("clamp fill after", 32'(fill_rows), 32'd0);

        // Beat in the rd_start cycle makes R=1
        run_drain(6'd5, 1'b1, 8'hAA, done_c, busy_c);
        chk("simul done cycle", done_c, 6);
        chk("simul busy cycles", busy_c, 6);
        chk("simul fill after", 32'(fill_rows), 32'd0);

        // Fill completely, then the 161st beat is held
        write_beats(160, 0, nrdy);
        chk("full ready during fill", nrdy, 0);
        chk("full wr_ready", 32'(wr_ready), 32'd0);
        chk("full fill", 32'(fill_rows), 32'd32);
        wr_valid = 1'b1; wr_data = 8'h55;
        tick(); tick();
        chk("full held en", 32'(mem_en_bus), 32'd0);
        chk("full held fill", 32'(fill_rows), 32'd32);
        wr_valid = 1'b0;
        run_drain(6'd32, 1'b0, 8'h00, done_c, busy_c);
        chk("full drain done", done_c, 37);
        chk("full drain busy", busy_c, 37);
        chk("full wr_ready after", 32'(wr_ready), 32'd1);
        chk("full fill after", 32'(fill_rows), 32'd0);

        // Reset while step 2 is being issued
        write_beats(10, 50, nrdy);
        chk("mid fill", 32'(fill_rows), 32'd2);
        rd_start = 1'b1; rd_rows = 6'd2;
        tick();
        rd_start = 1'b0;
        tick(); tick();
        chk("mid lane0 before rst", 32'(lane_valid[0]), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid rst lane_valid", 32'(lane_valid), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst fill", 32'(fill_rows), 32'd0);
        chk("mid rst r_addr", 32'(mem_r_addr), 32'd0);
        chk("mid rst wr_ready", 32'(wr_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid post wr_ready", 32'(wr_ready), 32'd1);
        run_drain(6'd2, 1'b0, 8'h00, done_c, busy_c);
        chk("mid post start ignored", busy_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/activation_memory_ctrl.md
# activation_memory_ctrl

Sequencer for `activation_memory_unit`. It takes a single-lane activation byte stream and stripes it round-robin across the BRAM banks: one byte per bank, and the row advances after every `BRAM_COUNT` bytes. On command it drains the stored rows with a per-bank diagonal skew, so the outputs feed the systolic array directly. It sits between the activation loader and the memory unit and is the only driver of that unit's control ports.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: row address width; depth = 2^ADDR_WIDTH rows.
- `DATA_WIDTH`, 8: activation width.
- `BRAM_COUNT`, 5: number of banks and output lanes.
- `SEL_WIDTH`, 4: width of each output-select field.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `wr_valid` in 1: write beat valid.
- `wr_ready` out 1: write beat accepted when high together with `wr_valid`.
- `wr_data` in DATA_WIDTH: write byte.
- `rd_start` in 1: one-cycle drain request.
- `rd_rows` in ADDR_WIDTH+1: number of rows to drain.
- `busy` out 1: high while in DRAIN.
- `rd_done` out 1: one-cycle pulse, coincident with the final lane valid.
- `lane_valid` out BRAM_COUNT: per-lane valid, aligned with the memory unit's `data_outs`.
- `fill_rows` out ADDR_WIDTH+1: rows touched so far; a partial row counts as one.
- `mem_en_bus` out BRAM_COUNT: one-hot write enable.
- `mem_w_addr` out ADDR_WIDTH: shared write row.
- `mem_data_in` out DATA_WIDTH: write data.
- `mem_r_addr` out BRAM_COUNT*ADDR_WIDTH: per-bank read row; bank b occupies bits [b*ADDR_WIDTH +: ADDR_WIDTH].
- `mem_data_out_sels` out BRAM_COUNT*SEL_WIDTH: lane-to-bank select.

## Operation
- States: IDLE and DRAIN.
- IDLE to DRAIN: on `rd_start` when the effective row count R = min(`rd_rows`, `fill_rows`) > 0. Otherwise `rd_start` is ignored.
- DRAIN to IDLE: after the last issue step.
- `rd_start` is ignored in DRAIN.
- `wr_ready` = (state == IDLE) && !full && `rst_n`.
- Write accept: `mem_en_bus` = one-hot(bank), `mem_w_addr` = row, `mem_data_in` = `wr_data`, all registered. Then bank increments. When bank wraps from BRAM_COUNT-1 to 0, row increments.
- `fill_rows` updates to row+1 on the first write into a new row.
- Full: set when the beat at row 2^ADDR_WIDTH-1, bank BRAM_COUNT-1 is accepted. `wr_ready` stays low until the drain completes.
- When no beat is accepted, `mem_en_bus` = 0 on the next cycle.
- Same-cycle write accept and `rd_start` in IDLE: the write counts. R is computed from `fill_rows` including that beat. DRAIN begins the next cycle.
- DRAIN runs steps t = 0 .. R+BRAM_COUNT-2, one step per cycle.
  - Bank b: `mem_r_addr[b]` = t-b when 0 ≤ t-b < R; otherwise 0 with that lane marked invalid.
- `mem_data_out_sels` field b = b (lane b reads bank b). This is constant, including during reset.
- DRAIN completion: write pointers (bank, row) = 0, `fill_rows` = 0, full cleared.
- Arithmetic: bank counter is modulo BRAM_COUNT; row counter is ADDR_WIDTH bits; step counter is ADDR_WIDTH+1 bits. R ≤ 2^ADDR_WIDTH.

## Timing
- Reset (`rst_n` low at an edge): state IDLE. `mem_en_bus`, `mem_w_addr`, `mem_data_in`, `mem_r_addr`, `lane_valid`, `busy`, `rd_done`, `fill_rows` all 0. Pointers 0. `wr_ready` 0 while `rst_n` is low.
- Reset mid-DRAIN aborts the drain, discards stored contents, and takes effect in the same edge.
- Write path: beat accepted at edge k → mem_* driven during cycle k+1 → memory writes at edge k+2.
- Read path: `mem_r_addr` registered at the step edge. The memory unit returns data one cycle later. `lane_valid[b]` is asserted in that data cycle and is a one-cycle-delayed copy of bank b's issue-valid.
- `busy` rises the cycle after `rd_start` and falls after the last step's data cycle.
- `wr_ready` returns the cycle after `rd_done`.
- Drain duration: R+BRAM_COUNT-1 issue cycles, plus 1 data cycle.

## Structure
- `activation_memory_pkg`: state enum {IDLE, DRAIN}, and a `onehot(bank)` function.
- Sub-module `skew_addr_gen`: takes t and R, produces `mem_r_addr` and issue-valid per bank. It is purely combinational and registered in the parent.
- The parent holds the FSM, write pointers, full flag, and output registers.

## Test plan
- Reset: hold `rst_n` low 3 cycles → all outputs 0 and `wr_ready` = 0; after release, `wr_ready` = 1 and `mem_data_out_sels` = {4,3,2,1,0}.
- Stripe: write 12 beats with data 5..16 → `mem_en_bus` steps 00001→10000 and repeats; `mem_w_addr` = 0 (×5), 1 (×5), 2 (×2); `fill_rows` = 3.
- Drain: then `rd_start`, `rd_rows` = 3 → 7 issue cycles. Lane 0 valid in data cycles 1–3 with bytes 5, 10, 15. Lane 4 valid in cycles 5–7 with bytes 9, 14. Lane 4's third row was never written, so its value is don't-care. `rd_done` coincides with lane 4's last valid; `fill_rows` = 0 afterwards.
- Full: 160 beats → `wr_ready` drops after beat 160 and beat 161 is held. A drain of 32 rows takes 36 issue cycles; `wr_ready` = 1 the cycle after `rd_done`.
- Ignored or clamped starts:
  - `rd_start` with `fill_rows` = 0 → ignored.
  - `rd_start` during DRAIN → no effect.
  - `rd_rows` = 5 with `fill_rows` = 3 → R = 3.
  - Simultaneous beat and `rd_start` → beat included in the drain.
- Reset mid-drain at step 2 → `lane_valid` = 0, `busy` = 0, `fill_rows` = 0 on the next cycle.
